// File: rtl/dec3x8_seq_if.sv
// Handshake/bus bundle between a sequencer and its requester.
// Requester side drives START/ABORT/FIRST/LAST/DWELL (and CONT when
// DEC3X8_SEQ_WRAP_EN is defined); the sequencer drives A0..A2, EN,
// BUSY and DONE. master = requester view, slave = sequencer view.
interface dec3x8_seq_if #(
   parameter int DWELL_W = 4
);
   logic               START;
   logic               ABORT;
   logic [2:0]         FIRST;
   logic [2:0]         LAST;
   logic [DWELL_W-1:0] DWELL;
`ifdef DEC3X8_SEQ_WRAP_EN
   logic               CONT;
`endif
   logic               A0;
   logic               A1;
   logic               A2;
   logic               EN;
   logic               BUSY;
   logic               DONE;

`ifdef DEC3X8_SEQ_WRAP_EN
   modport master (
      output START, ABORT, FIRST, LAST, DWELL, CONT,
      input  A0, A1, A2, EN, BUSY, DONE
   );
   modport slave (
      input  START, ABORT, FIRST, LAST, DWELL, CONT,
      output A0, A1, A2, EN, BUSY, DONE
   );
`else
   modport master (
      output START, ABORT, FIRST, LAST, DWELL,
      input  A0, A1, A2, EN, BUSY, DONE
   );
   modport slave (
      input  START, ABORT, FIRST, LAST, DWELL,
      output A0, A1, A2, EN, BUSY, DONE
   );
`endif
endinterface

// File: rtl/dec3x8_seq.sv
// Address sequencer for an upstream 3-to-8 decoder.
// Ports: CLK, RSTN (async active-low), bus (dec3x8_seq_if.slave):
//   in  START, ABORT, FIRST[2:0], LAST[2:0], DWELL[DWELL_W-1:0]
//   in  CONT (only with DEC3X8_SEQ_WRAP_EN defined: loop FIRST..LAST)
//   out A0..A2, EN, BUSY, DONE (all registered)
// Per address: SETUP (EN low), DWELL cycles EN high, GAP_CYC cycles EN low.
module dec3x8_seq #(
   parameter int DWELL_W = 4,
   parameter int GAP_CYC = 1
) (
   input logic          CLK,
   input logic          RSTN,
   dec3x8_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_M1 =
      (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

   state_t             state_q, state_d;
   logic [2:0]         addr_q, addr_d;
   logic [2:0]         first_q, first_d;
   logic [2:0]         last_q, last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [3:0]         gcnt_q, gcnt_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap;
   logic               adv;

`ifdef DEC3X8_SEQ_WRAP_EN
   assign wrap = bus.CONT;
`else
   assign wrap = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      first_d = first_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      adv     = 1'b0;

      if (bus.ABORT) begin
         // address is deliberately held on abort
         state_d = S_IDLE;
         en_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.START) begin
                  first_d = bus.FIRST;
                  last_d  = bus.LAST;
                  addr_d  = bus.FIRST;
                  // a zero dwell still gives one EN-high cycle
                  dwell_d = (bus.DWELL == '0) ?
                            DWELL_W'(1) : bus.DWELL;
                  state_d = S_SETUP;
                  busy_d  = 1'b1;
                  en_d    = 1'b0;
               end
            end
            S_SETUP: begin
               state_d = S_ACTIVE;
               en_d    = 1'b1;
               cnt_d   = dwell_q - DWELL_W'(1);
            end
            S_ACTIVE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else if (GAP_CYC == 0) begin
                  adv = 1'b1;
               end else begin
                  state_d = S_GAP;
                  en_d    = 1'b0;
                  gcnt_d  = GAP_M1;
               end
            end
            S_GAP: begin
               if (gcnt_q != '0) begin
                  gcnt_d = gcnt_q - 4'd1;
               end else begin
                  adv = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         // end of one address window: finish, wrap or step
         if (adv) begin
            en_d = 1'b0;
            if (addr_q == last_q && !wrap) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_SETUP;
               addr_d  = (addr_q == last_q) ?
                         first_q : addr_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         first_q <= '0;
         last_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         first_q <= first_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.A0   = addr_q[0];
   assign bus.A1   = addr_q[1];
   assign bus.A2   = addr_q[2];
   assign bus.EN   = en_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;

endmodule

// File: tb/tb_dec3x8_seq.sv
// Bench for dec3x8_seq: expected per-cycle output traces are built
// from the sequencing rules and compared cycle by cycle.
module tb_dec3x8_seq;

   localparam int DW  = 4;
   localparam int GAP = 1;

   logic CLK;
   logic RSTN;
   int   n_chk;
   int   n_fail;

   logic [5:0] exp_q[$];
   logic [2:0] prev_a;
   logic       prev_en;

   dec3x8_seq_if #(.DWELL_W(DW)) bus ();

   dec3x8_seq #(
      .DWELL_W(DW),
      .GAP_CYC(GAP)
   ) dut (
      .CLK (CLK),
      .RSTN(RSTN),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [5:0] obs();
      return {bus.A2, bus.A1, bus.A0,
              bus.EN, bus.BUSY, bus.DONE};
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // trace entry: {A[2:0], EN, BUSY, DONE}
   task automatic build(input logic [2:0] f,
                        input logic [2:0] l,
                        input int dw,
                        input int passes);
      int n;
      int d;
      logic [2:0] a;
      exp_q.delete();
      n = ((int'(l) - int'(f) + 8) % 8) + 1;
      d = (dw == 0) ? 1 : dw;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) begin
            a = 3'((int'(f) + i) % 8);
            exp_q.push_back({a, 3'b010});
            for (int k = 0; k < d; k++)
               exp_q.push_back({a, 3'b110});
            for (int k = 0; k < GAP; k++)
               exp_q.push_back({a, 3'b010});
         end
      end
      exp_q.push_back({l, 3'b001});
      exp_q.push_back({l, 3'b000});
   endtask

   task automatic run(input logic [2:0] f,
                      input logic [2:0] l,
                      input int dw,
                      input int abort_at,
                      input bit mid_start,
                      input int passes,
                      input int rst_at);
      int per;
      logic [5:0] g;
      per = 0;
      build(f, l, dw, passes);
      per = (exp_q.size() - 2) / passes;
      @(negedge CLK);
      bus.START = 1'b1;
      bus.FIRST = f;
      bus.LAST  = l;
      bus.DWELL = DW'(dw);
`ifdef DEC3X8_SEQ_WRAP_EN
      bus.CONT  = (passes > 1);
`endif
      @(negedge CLK);
      bus.START = mid_start;
      if (mid_start) begin
         bus.FIRST = ~f;
         bus.LAST  = f;
         bus.DWELL = DW'(dw + 3);
      end
      prev_a  = exp_q[0][5:3];
      prev_en = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         g = obs();
         check("trace", 32'(g), 32'(exp_q[i]));
         if (g[5:3] != prev_a)
            check("a_chg_en", 32'({prev_en, g[2]}), 32'd0);
         if (prev_en && g[2])
            check("a_hold", 32'(g[5:3]), 32'(prev_a));
         prev_a  = g[5:3];
         prev_en = g[2];
         if (i == rst_at) begin
            RSTN = 1'b0;
            #1;
            check("rst_async", 32'(obs()), 32'd0);
            @(negedge CLK);
            check("rst_hold", 32'(obs()), 32'd0);
            RSTN = 1'b1;
            bus.START = 1'b0;
            break;
         end
         if (passes > 1 && i == (passes - 1) * per) begin
`ifdef DEC3X8_SEQ_WRAP_EN
            bus.CONT = 1'b0;
`endif
         end
         if (i == exp_q.size() - 2)
            bus.START = 1'b0;
         if (i == abort_at) begin
            bus.ABORT = 1'b1;
            bus.START = 1'b1;
            @(negedge CLK);
            check("abort", 32'(obs()),
                  32'({exp_q[i][5:3], 3'b000}));
            bus.ABORT = 1'b0;
            bus.START = 1'b0;
            @(negedge CLK);
            check("abort_idle", 32'(obs()),
                  32'({exp_q[i][5:3], 3'b000}));
            break;
         end
         @(negedge CLK);
      end
      bus.START = 1'b0;
   endtask

   initial begin
      int size;
      int ab;
      logic [2:0] f;
      logic [2:0] l;
      int dw;
      n_chk  = 0;
      n_fail = 0;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      bus.FIRST = '0;
      bus.LAST  = '0;
      bus.DWELL = '0;
`ifdef DEC3X8_SEQ_WRAP_EN
      bus.CONT  = 1'b0;
`endif
      RSTN = 1'b1;
      #2 RSTN = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset", 32'(obs()), 32'd0);
      RSTN = 1'b1;
      @(negedge CLK);
      check("idle", 32'(obs()), 32'd0);

      // full sweep, wrap-around, zero dwell
      run(3'd0, 3'd7, 2, -1, 1'b0, 1, -1);
      run(3'd6, 3'd1, 1, -1, 1'b0, 1, -1);
      run(3'd3, 3'd3, 0, -1, 1'b0, 1, -1);
      // abort in 2nd ACTIVE cycle of address 4
      run(3'd0, 3'd7, 2, 4 * (2 + GAP + 1) + 2,
          1'b0, 1, -1);
      // START with new FIRST while busy
      run(3'd1, 3'd4, 1, -1, 1'b1, 1, -1);
      // reset during ACTIVE of address 1
      run(3'd0, 3'd7, 3, -1, 1'b0, 1, 6);

      // ABORT together with START in IDLE
      @(negedge CLK);
      bus.START = 1'b1;
      bus.ABORT = 1'b1;
      @(negedge CLK);
      check("abort_start", 32'(bus.BUSY), 32'd0);
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      @(negedge CLK);
      check("abort_start2", 32'(bus.BUSY), 32'd0);

      for (int r = 0; r < 25; r++) begin
         f  = 3'($urandom_range(0, 7));
         l  = 3'($urandom_range(0, 7));
         dw = $urandom_range(0, 4);
         build(f, l, dw, 1);
         size = exp_q.size();
         ab = ($urandom_range(0, 2) == 0) ?
              $urandom_range(0, size - 3) : -1;
         run(f, l, dw, ab, 1'($urandom_range(0, 1)), 1, -1);
      end

`ifdef DEC3X8_SEQ_WRAP_EN
      run(3'd2, 3'd3, 1, -1, 1'b0, 3, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
